store_lane_unit: RTL and testbench
==================================

STORE_LANE_UNIT -- requirements
Module: store_lane_unit

Interface
REQ-001 Parameter: DEPTH, default 2, number of buffered store entries (power of two, at least 2).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  store request from the MEM stage is present.
REQ-005 Port: req_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: req_addr  input  32  byte address of the store.
REQ-007 Port: req_data  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
REQ-008 Port: req_size  input  2  store size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Port: mem_valid  output  1  a steered write is presented to data memory.
REQ-010 Port: mem_ready  input  1  data memory accepts the write this cycle.
REQ-011 Port: mem_addr  output  32  word-aligned address, with bits [1:0] always 0.
REQ-012 Port: mem_wdata  output  32  lane-steered write data.
REQ-013 Port: mem_be  output  4  byte enables, where bit i enables lane [8i+7:8i].
REQ-014 Port: misalign  output  1  one-cycle address-error pulse to the exception unit.
REQ-015 Port: misalign_addr  output  32  faulting byte address, held until the next misalign pulse.

Function
REQ-016 The unit SHALL accept a request only on a cycle with req_valid=1 and req_ready=1.
REQ-017 req_ready SHALL be 1 exactly when the entry count is less than DEPTH, with no full-buffer pass-through.
REQ-018 An accepted request SHALL be classed misaligned when any of the following holds: size=01 and addr[0]=1; size=10 and addr[1:0]!=00; size=11.
REQ-019 A misaligned request SHALL NOT be enqueued, and misalign SHALL pulse high for exactly the cycle after acceptance, with misalign_addr = req_addr.
REQ-020 Byte steering SHALL be: wdata = {4{data[7:0]}}, be = 0001 shifted left by addr[1:0].
REQ-021 Half steering SHALL be: wdata = {2{data[15:0]}}, be = 1100 when addr[1]=1, otherwise 0011.
REQ-022 Word steering SHALL be: wdata = data, be = 1111.
REQ-023 Steering SHALL be computed at enqueue time, and each entry SHALL store {word addr, wdata, be}.
REQ-024 mem_valid SHALL be 1 whenever the count is greater than 0, and mem_addr/mem_wdata/mem_be SHALL reflect the oldest entry.
REQ-025 Latency SHALL be one cycle: a request accepted with the buffer empty appears on mem_* in the next cycle.
REQ-026 The head entry SHALL be popped on a cycle with mem_valid=1 and mem_ready=1.
REQ-027 mem_* SHALL remain stable while mem_valid=1 and mem_ready=0.
REQ-028 Entries SHALL be issued in acceptance order, and the read/write pointers SHALL wrap modulo DEPTH.
REQ-029 On a simultaneous aligned enqueue and pop, the count SHALL stay unchanged and both operations SHALL take effect.
REQ-030 On a simultaneous misaligned accept and pop, the pop SHALL proceed and the count SHALL decrement.
REQ-031 A count of DEPTH SHALL hold req_ready=0 until a pop occurs, with req_ready rising in the cycle after the pop.

Reset
REQ-032 While rst_n=0, asynchronously: count=0, pointers=0, mem_valid=0, misalign=0, misalign_addr=0.
REQ-033 req_ready SHALL be 1 after reset deassertion, and mem_addr/mem_wdata/mem_be SHALL read 0 while empty after reset.
REQ-034 Asserting rst_n mid-operation SHALL discard all buffered entries with no write issued.
REQ-035 Storage arrays SHALL NOT require reset, and only control state SHALL be reset.

Structure
REQ-036 The req_size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) SHALL reside in the shared package my_lib.
REQ-037 One sub-module, store_fifo (parameterised width/DEPTH, valid/ready on both sides), SHALL hold the entries.
REQ-038 Steering and misalignment detection SHALL be combinational logic in store_lane_unit, ahead of store_fifo.

Verification
REQ-039 SB addr=0x1003, data=0x000000AB, mem_ready=1 -> the next cycle shows mem_addr=0x1000, wdata=0xABABABAB, be=1000, and the following cycle shows mem_valid=0.
REQ-040 SH addr=0x2002, data=0x0000BEEF -> wdata=0xBEEFBEEF, be=1100; SW addr=0x2004, data=0x12345678 -> be=1111, wdata unchanged.
REQ-041 SW addr=0x3001 -> misalign=1 for one cycle, misalign_addr=0x3001, mem_valid stays 0; the same check SHALL apply to size=11 at an aligned address.
REQ-042 mem_ready=0 with 3 back-to-back SW -> 2 accepted, req_ready=0 on the 3rd with mem_* stable; after mem_ready=1, writes issue in order and the 3rd is accepted once space frees.
REQ-043 Continuous req_valid with mem_ready=1 for 8 stores -> the count never exceeds 1, one write issues per cycle, and the pointers wrap correctly.
REQ-044 Assert rst_n=0 with 2 entries buffered and mem_ready=0 -> mem_valid=0 immediately; after release req_ready=1 and no stale write is issued.

Source files
------------

// File: rtl/store_lane_unit_pkg.sv
// Shared definitions for the store lane unit.
//   size_e   : encoding of req_size (byte / half / word / reserved)
//   ENTRY_W  : width of one buffered store entry {word addr, wdata, be}
package my_lib;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int WADDR_W = 30;
    localparam int ENTRY_W = WADDR_W + 32 + 4;

endpackage

// File: rtl/store_lane_unit_fifo.sv
// store_fifo: small circular buffer holding steered store entries.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : write side; a push happens when both are 1
//   in_data             : entry to push
//   out_valid/out_ready : read side; a pop happens when both are 1
//   out_data            : oldest entry (raw storage, only meaningful when out_valid)
// Handshake: a transfer occurs on a rising edge where valid and ready are both 1;
// valid never depends on ready on the same side. in_ready is purely a function of
// the stored count, so a full buffer does not accept even when a pop is in flight.
module store_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign in_ready  = (count < (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage carries no reset; only pointers and count are control state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_lane_unit.sv
// store_lane_unit: steers MEM-stage stores onto byte lanes, buffers them and
// issues them to data memory in order; flags misaligned stores.
//   req_valid/req_ready : store request handshake from the MEM stage
//   req_addr/data/size  : byte address, right-aligned data, size code
//   mem_valid/mem_ready : write handshake to data memory
//   mem_addr/wdata/be   : word address, lane-steered data, byte enables
//   misalign            : one-cycle pulse the cycle after a misaligned accept
//   misalign_addr       : faulting byte address, held until the next pulse
// Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
module store_lane_unit
    import my_lib::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign,
    output logic [31:0] misalign_addr
);

    size_e               size;
    logic                bad_align;
    logic [31:0]         st_wdata;
    logic [3:0]          st_be;
    logic                accept;
    logic                push;
    logic                fifo_in_ready;
    logic                fifo_out_valid;
    logic [ENTRY_W-1:0]  fifo_in_data;
    logic [ENTRY_W-1:0]  fifo_out_data;

    assign size = size_e'(req_size);

    // Lane steering and alignment check, done before the entry is buffered.
    always_comb begin
        bad_align = 1'b0;
        st_wdata  = req_data;
        st_be     = 4'b1111;
        case (size)
            SZ_BYTE: begin
                st_wdata = {4{req_data[7:0]}};
                st_be    = 4'b0001 << req_addr[1:0];
            end
            SZ_HALF: begin
                st_wdata  = {2{req_data[15:0]}};
                st_be     = req_addr[1] ? 4'b1100 : 4'b0011;
                bad_align = req_addr[0];
            end
            SZ_WORD: begin
                st_wdata  = req_data;
                st_be     = 4'b1111;
                bad_align = (req_addr[1:0] != 2'b00);
            end
            default: begin
                bad_align = 1'b1;
            end
        endcase
    end

    assign req_ready    = fifo_in_ready;
    assign accept       = req_valid & fifo_in_ready;
    assign push         = accept & ~bad_align;
    assign fifo_in_data = {req_addr[31:2], st_wdata, st_be};

    store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (fifo_out_valid),
        .out_ready (mem_ready),
        .out_data  (fifo_out_data)
    );

    // Storage is not reset, so the head is masked to keep mem_* at 0 when empty.
    assign mem_valid = fifo_out_valid;
    assign mem_addr  = fifo_out_valid ? {fifo_out_data[ENTRY_W-1:36], 2'b00} : 32'h0;
    assign mem_wdata = fifo_out_valid ? fifo_out_data[35:4] : 32'h0;
    assign mem_be    = fifo_out_valid ? fifo_out_data[3:0]  : 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign      <= 1'b0;
            misalign_addr <= 32'h0;
        end else begin
            misalign <= accept & bad_align;
            if (accept & bad_align) begin
                misalign_addr <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_store_lane_unit.sv
module tb_store_lane_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic [31:0] misalign_addr;

    store_lane_unit #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_size      (req_size),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .misalign      (misalign),
        .misalign_addr (misalign_addr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    // Each expected entry: {byte-0 address of the word, wdata, be}.
    logic [67:0] exp_q[$];
    logic        exp_mis;
    logic [31:0] exp_mis_addr;
    int          n_checks;
    int          n_fail;
    int          max_fill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (from the store rules) ----------------
    function automatic bit is_bad(input logic [31:0] a, input logic [1:0] s);
        int bytes;
        if (s == 2'd3) return 1'b1;
        bytes = 1 << s;
        return (a % bytes) != 0;
    endfunction

    function automatic logic [67:0] make_entry(input logic [31:0] a, input logic [31:0] d,
                                               input logic [1:0] s);
        logic [31:0] w;
        logic [3:0]  be;
        int          bytes;
        bytes = 1 << s;
        be    = 4'(((1 << bytes) - 1) << (a % 4));
        if (s == 2'd0)      w = {24'h0, d[7:0]}  * 32'h0101_0101;
        else if (s == 2'd1) w = {16'h0, d[15:0]} * 32'h0001_0001;
        else                w = d;
        return {a - (a % 4), w, be};
    endfunction

    task automatic check_outputs(input string tag);
        logic [67:0] head;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_q.size() < DEPTH));
        check({tag, ".mem_valid"}, 32'(mem_valid), 32'(exp_q.size() > 0));
        head = (exp_q.size() > 0) ? exp_q[0] : 68'h0;
        check({tag, ".mem_addr"},  mem_addr,       head[67:36]);
        check({tag, ".mem_wdata"}, mem_wdata,      head[35:4]);
        check({tag, ".mem_be"},    32'(mem_be),    32'(head[3:0]));
        check({tag, ".misalign"},  32'(misalign),  32'(exp_mis));
        check({tag, ".mis_addr"},  misalign_addr,  exp_mis_addr);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; drives for one rising edge, then checks.
    task automatic step(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s, input logic mr);
        bit do_pop;
        bit do_acc;
        bit bad;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        mem_ready = mr;
        do_pop = (exp_q.size() > 0) && mr;
        do_acc = v && (exp_q.size() < DEPTH);
        bad    = is_bad(a, s);
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (do_acc && !bad) exp_q.push_back(make_entry(a, d, s));
        exp_mis = do_acc && bad;
        if (do_acc && bad) exp_mis_addr = a;
        if (exp_q.size() > max_fill) max_fill = exp_q.size();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic mr);
        step(tag, 1'b0, 32'h0, 32'h0, 2'd0, mr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_mis      = 1'b0;
        exp_mis_addr = 32'h0;
        check("rst.mem_valid", 32'(mem_valid), 32'h0);
        check("rst.misalign",  32'(misalign),  32'h0);
        check("rst.mis_addr",  misalign_addr,  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("post_rst");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        n_checks  = 0;
        n_fail    = 0;
        max_fill  = 0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'd0;
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        exp_mis      = 1'b0;
        exp_mis_addr = 32'h0;
        #2;
        do_reset();

        // Byte store at lane 3, then empty again.
        step("sb",   1'b1, 32'h0000_1003, 32'h0000_00AB, 2'd0, 1'b1);
        check("sb.wdata_const", mem_wdata, 32'hABAB_ABAB);
        check("sb.be_const",    32'(mem_be), 32'h8);
        idle("sb_drain", 1'b1);
        check("sb.empty_const", 32'(mem_valid), 32'h0);

        // Half at upper lanes, then a word.
        step("sh", 1'b1, 32'h0000_2002, 32'h0000_BEEF, 2'd1, 1'b1);
        check("sh.wdata_const", mem_wdata, 32'hBEEF_BEEF);
        step("sw", 1'b1, 32'h0000_2004, 32'h1234_5678, 2'd2, 1'b1);
        check("sw.be_const", 32'(mem_be), 32'hF);
        idle("sw_drain", 1'b1);

        // Misaligned word and reserved size at an aligned address.
        step("mis_sw", 1'b1, 32'h0000_3001, 32'hDEAD_BEEF, 2'd2, 1'b1);
        check("mis_sw.addr_const", misalign_addr, 32'h0000_3001);
        idle("mis_sw_end", 1'b1);
        step("mis_rsvd", 1'b1, 32'h0000_4000, 32'h1111_2222, 2'd3, 1'b1);
        idle("mis_rsvd_end", 1'b1);
        check("mis_rsvd.held", misalign_addr, 32'h0000_4000);

        // Back-pressure: three words with memory stalled.
        step("bp1", 1'b1, 32'h0000_5000, 32'hA000_0001, 2'd2, 1'b0);
        step("bp2", 1'b1, 32'h0000_5004, 32'hA000_0002, 2'd2, 1'b0);
        step("bp3", 1'b1, 32'h0000_5008, 32'hA000_0003, 2'd2, 1'b0);
        step("bp3s", 1'b1, 32'h0000_5008, 32'hA000_0003, 2'd2, 1'b0);
        step("bp3r", 1'b1, 32'h0000_5008, 32'hA000_0003, 2'd2, 1'b1);
        step("bp3a", 1'b1, 32'h0000_5008, 32'hA000_0003, 2'd2, 1'b1);
        idle("bp_d1", 1'b1);
        idle("bp_d2", 1'b1);
        idle("bp_d3", 1'b1);

        // Streaming: eight stores back to back with memory always ready.
        max_fill = 0;
        for (int i = 0; i < 8; i++) begin
            step("stream", 1'b1, 32'h0000_6000 + 32'(i * 4), $urandom, 2'd2, 1'b1);
        end
        idle("stream_end", 1'b1);
        check("stream.max_fill", 32'(max_fill), 32'd1);

        // Reset with two entries buffered and memory stalled.
        step("rb1", 1'b1, 32'h0000_7000, 32'hC0DE_0001, 2'd2, 1'b0);
        step("rb2", 1'b1, 32'h0000_7004, 32'hC0DE_0002, 2'd2, 1'b0);
        req_valid = 1'b0;
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) idle("rst_flush", 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << s) - 1);
            step("rand", 1'($urandom_range(0, 1)), a, $urandom, s,
                 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) idle("rand_drain", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
